hls_ip_job_arbiter: RTL

Round-robin job scheduler that shares one HLS accelerator instance (single-input / single-output streaming HWPE) between N_REQ requesters, e.g. two cores or a core plus a DMA.
- Accepts one job descriptor per requester handshake: input/output base address and lengths.
- Issues it to the accelerator controller, waits for completion, then returns a done pulse to the owning requester.
- Sits between the requester-side register ports and the accelerator's start/done control interface.

---
 rtl/hls_ip_job_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hls_ip_job_arbiter.sv
// Purpose: round-robin scheduler sharing one start/done HLS accelerator between N_REQ requesters.
// Latency: accept -> acc_start_o >= 1 cycle; acc_done_i at t -> done_o at t+1; next accept earliest t+2.
// Backpressure: one job in flight; req_ready_o stays low while busy; start is held until acc_ready_i.
//
// Ports:
//   clk_i, rst_ni (async, active-low), clear_i (sync soft clear, highest priority)
//   req_valid_i/req_ready_o        per-requester job handshake, ready is one-hot or zero
//   req_{in,out}_{addr,len}_i      packed descriptors, requester i in slice i
//   done_o/err_o                   one-cycle completion pulse to the owner, err qualifies it
//   busy_o, grant_id_o             job owned / id of current or last owner
//   acc_ready_i/acc_start_o/acc_done_i/acc_abort_o and latched acc_* job fields
//
// Optional build macro: HLS_IP_JOB_ARBITER_WATCHDOG_EN adds a RUN-state timeout of
// TIMEOUT_CYC cycles that aborts the accelerator and completes the job with err_o=1.
module hls_ip_job_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0]   req_in_addr_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_out_addr_i,
    input  logic [N_REQ*LEN_W-1:0]    req_in_len_i,
    input  logic [N_REQ*LEN_W-1:0]    req_out_len_i,
    output logic [N_REQ-1:0]          done_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic [$clog2(N_REQ)-1:0]  grant_id_o,
    input  logic                      acc_ready_i,
    output logic                      acc_start_o,
    output logic [ADDR_W-1:0]         acc_in_addr_o,
    output logic [ADDR_W-1:0]         acc_out_addr_o,
    output logic [LEN_W-1:0]          acc_in_len_o,
    output logic [LEN_W-1:0]          acc_out_len_o,
    input  logic                      acc_done_i,
    output logic                      acc_abort_o
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [LEN_W-1:0]  in_len_q, in_len_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;

    // Combinational pulses are suppressed while clear_i or rst_ni is active so
    // that nothing is handshaken in a cycle whose state is being discarded.
    logic live;
    assign live = rst_ni & ~clear_i;

    logic wdog_expire;

    // Round-robin search: first valid requester starting at rr_ptr_q.
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic accept;
    assign accept      = live && (state_q == S_IDLE) && grant_vld;
    assign req_ready_o = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        err_d      = err_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        in_len_d   = in_len_q;
        out_len_d  = out_len_q;
        if (clear_i) begin
            state_d    = S_IDLE;
            rr_ptr_d   = '0;
            grant_id_d = '0;
            err_d      = 1'b0;
            in_addr_d  = '0;
            out_addr_d = '0;
            in_len_d   = '0;
            out_len_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_id_d = grant_idx;
                        in_addr_d  = req_in_addr_i[grant_idx*ADDR_W +: ADDR_W];
                        out_addr_d = req_out_addr_i[grant_idx*ADDR_W +: ADDR_W];
                        in_len_d   = req_in_len_i[grant_idx*LEN_W +: LEN_W];
                        out_len_d  = req_out_len_i[grant_idx*LEN_W +: LEN_W];
                        // An empty stream would never complete; skip it and report failure.
                        if ((in_len_d == '0) || (out_len_d == '0)) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (acc_ready_i) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // A real completion on the expiry cycle takes precedence.
                    if (acc_done_i) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (wdog_expire) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
                default: begin
                    rr_ptr_d = (grant_id_q == ID_W'(N_REQ-1)) ? '0 : grant_id_q + 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            err_q      <= 1'b0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            in_len_q   <= '0;
            out_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            err_q      <= err_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            in_len_q   <= in_len_d;
            out_len_q  <= out_len_d;
        end
    end

`ifdef HLS_IP_JOB_ARBITER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    // Counts cycles spent in RUN; held at zero everywhere else so it starts
    // from zero on every RUN entry.
    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;

    assign wdog_expire = (state_q == S_RUN) && (wdog_cnt_q == WD_W'(TIMEOUT_CYC));

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (clear_i || (state_q != S_RUN)) begin
            wdog_cnt_d = '0;
        end else if (!wdog_expire) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    assign acc_abort_o = live && wdog_expire && !acc_done_i;
`else
    logic [31:0] wdog_limit_unused;
    assign wdog_limit_unused = 32'(TIMEOUT_CYC);
    assign wdog_expire       = 1'b0;
    assign acc_abort_o       = 1'b0;
`endif

    assign acc_start_o    = live && (state_q == S_ISSUE) && acc_ready_i;
    assign done_o         = (live && (state_q == S_DONE)) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q) : '0;
    assign err_o          = live && (state_q == S_DONE) && err_q;
    assign busy_o         = (state_q != S_IDLE);
    assign grant_id_o     = grant_id_q;
    assign acc_in_addr_o  = in_addr_q;
    assign acc_out_addr_o = out_addr_q;
    assign acc_in_len_o   = in_len_q;
    assign acc_out_len_o  = out_len_q;

endmodule
